// File: rtl/jtpopeye_romrq_arb.sv
// Multi-client SDRAM ROM arbiter: each byte-wide client owns a one-word cache, misses are fetched round-robin as 32-bit pairs.
// Hits answer one cycle after addr/cs settle; a miss keeps ok low until its own fill, sdram_req is held until sdram_ack.
module jtpopeye_romrq_arb #(
  parameter int CHANNELS = 4,
  parameter int CH_AW    = 15,
  parameter int SDR_AW   = 22,
  parameter logic [CHANNELS*SDR_AW-1:0] OFFSET = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       cs,
  input  logic [CHANNELS*CH_AW-1:0] addr,
  output logic [CHANNELS*8-1:0]     dout,
  output logic [CHANNELS-1:0]       ok,
  input  logic                      downloading,
  input  logic                      loop_rst,
  output logic                      sdram_req,
  output logic [SDR_AW-1:0]         sdram_addr,
  input  logic                      sdram_ack,
  input  logic                      data_rdy,
  input  logic [31:0]               data_read,
  output logic                      refresh_en
);
  localparam int TW  = CH_AW - 2;
  localparam int RRW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t              state_q, state_d;
  logic [CHANNELS-1:0] valid_q, valid_d;
  logic [TW-1:0]       tag_q  [CHANNELS];
  logic [TW-1:0]       tag_d  [CHANNELS];
  logic [31:0]         word_q [CHANNELS];
  logic [31:0]         word_d [CHANNELS];
  logic [7:0]          dout_q [CHANNELS];
  logic [7:0]          dout_d [CHANNELS];
  logic [CHANNELS-1:0] ok_q, ok_d;
  logic [RRW-1:0]      rr_q, rr_d;
  logic [RRW-1:0]      gnt_q, gnt_d;
  logic [TW-1:0]       gtag_q, gtag_d;
  logic                sdram_req_q, sdram_req_d;
  logic [SDR_AW-1:0]   sdram_addr_q, sdram_addr_d;
  logic                refresh_en_q, refresh_en_d;

  logic [CH_AW-1:0]    ch_addr  [CHANNELS];
  logic [SDR_AW-1:0]   req_addr [CHANNELS];
  logic [CHANNELS-1:0] hit, pending;
  logic                flush, fill, found;
  logic [RRW-1:0]      sel;

  function automatic logic [7:0] lane(input logic [31:0] w, input logic [1:0] b);
    case (b)
      2'd0:    lane = w[7:0];
      2'd1:    lane = w[15:8];
      2'd2:    lane = w[23:16];
      default: lane = w[31:24];
    endcase
  endfunction

  // Per-channel lookup; the SDRAM word address wraps modulo 2^SDR_AW.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      ch_addr[i]  = addr[i*CH_AW +: CH_AW];
      hit[i]      = valid_q[i] && (tag_q[i] == ch_addr[i][CH_AW-1:2]);
      pending[i]  = cs[i] && !hit[i] && !downloading;
      req_addr[i] = OFFSET[i*SDR_AW +: SDR_AW] + SDR_AW'({ch_addr[i][CH_AW-1:2], 1'b0});
    end
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    rr_d         = rr_q;
    gnt_d        = gnt_q;
    gtag_d       = gtag_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    fill         = 1'b0;
    found        = 1'b0;
    sel          = '0;
    flush        = downloading | loop_rst;
    refresh_en_d = (state_q == IDLE) && (pending == '0) && !flush;
    for (int i = 0; i < CHANNELS; i++) begin
      tag_d[i]  = tag_q[i];
      word_d[i] = word_q[i];
      ok_d[i]   = cs[i] && hit[i] && !flush;
      dout_d[i] = hit[i] ? lane(word_q[i], ch_addr[i][1:0]) : dout_q[i];
    end

    case (state_q)
      IDLE: begin
        // Scan upward from the channel after the last one served.
        for (int k = 1; k <= CHANNELS; k++) begin
          if (!found && pending[RRW'((int'(rr_q) + k) % CHANNELS)]) begin
            found = 1'b1;
            sel   = RRW'((int'(rr_q) + k) % CHANNELS);
          end
        end
        if (found) begin
          gnt_d        = sel;
          gtag_d       = ch_addr[sel][CH_AW-1:2];
          sdram_addr_d = req_addr[sel];
          sdram_req_d  = 1'b1;
          state_d      = REQ;
        end
      end
      REQ: begin
        if (sdram_ack) begin
          sdram_req_d = 1'b0;
          if (data_rdy) begin
            fill    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (data_rdy) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The fill uses the tag latched at grant time, not the client's current address.
    if (fill) begin
      valid_d[gnt_q] = 1'b1;
      tag_d[gnt_q]   = gtag_q;
      word_d[gnt_q]  = data_read;
      rr_d           = gnt_q;
    end

    if (flush) begin
      valid_d     = '0;
      sdram_req_d = 1'b0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      ok_q         <= '0;
      rr_q         <= '0;
      gnt_q        <= '0;
      gtag_q       <= '0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      refresh_en_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        tag_q[i]  <= '0;
        word_q[i] <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      ok_q         <= ok_d;
      rr_q         <= rr_d;
      gnt_q        <= gnt_d;
      gtag_q       <= gtag_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      refresh_en_q <= refresh_en_d;
      for (int i = 0; i < CHANNELS; i++) begin
        tag_q[i]  <= tag_d[i];
        word_q[i] <= word_d[i];
        dout_q[i] <= dout_d[i];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_dout
    assign dout[g*8 +: 8] = dout_q[g];
  end

  assign ok         = ok_q;
  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;
  assign refresh_en = refresh_en_q;

endmodule

// File: tb/tb_jtpopeye_romrq_arb.sv
// Bench for jtpopeye_romrq_arb: ROM model behind an SDRAM responder, byte-level expectations in a scoreboard.
module tb_jtpopeye_romrq_arb;
  localparam int CH = 4;
  localparam int AW = 15;
  localparam int SW = 22;
  localparam logic [CH*SW-1:0] OFFS = {22'h3FFFF0, 22'h200000, 22'h001000, 22'h000100};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CH-1:0]   cs = '0;
  logic [CH*AW-1:0] addr = '0;
  logic [CH*8-1:0] dout;
  logic [CH-1:0]   ok;
  logic            downloading = 1'b0;
  logic            loop_rst = 1'b0;
  logic            sdram_req;
  logic [SW-1:0]   sdram_addr;
  logic            sdram_ack;
  logic            data_rdy;
  logic [31:0]     data_read;
  logic            refresh_en;

  always #25 clk = ~clk;

  jtpopeye_romrq_arb #(.CHANNELS(CH), .CH_AW(AW), .SDR_AW(SW), .OFFSET(OFFS)) dut (
    .clk(clk), .rst(rst), .cs(cs), .addr(addr), .dout(dout), .ok(ok),
    .downloading(downloading), .loop_rst(loop_rst),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .data_read(data_read), .refresh_en(refresh_en)
  );

  typedef struct { int ch; logic [AW-1:0] a; logic [7:0] b; int stamp; } exp_t;
  exp_t          exp_q[$];
  logic [SW-1:0] exp_req[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_req = 0;
  int ack_dly = 1;
  int dat_dly = 2;
  bit same = 1'b0;
  bit hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM contents as seen at each 16-bit SDRAM word.
  function automatic logic [15:0] rom16(input logic [SW-1:0] wa);
    logic [31:0] m;
    m = {10'd0, wa} * 32'h9E3779B1;
    return m[31:16] ^ m[15:0];
  endfunction

  function automatic logic [SW-1:0] offs_of(input int c);
    return OFFS[c*SW +: SW];
  endfunction

  // Byte 'a' of client c lives in 16-bit word OFFSET_c + a/2, low byte first.
  function automatic logic [7:0] exp_byte(input int c, input logic [AW-1:0] a);
    logic [15:0] w;
    w = rom16(SW'(offs_of(c) + SW'(a >> 1)));
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  // Even word of the pair holding byte 'a'.
  function automatic logic [SW-1:0] word_req(input int c, input logic [AW-1:0] a);
    return SW'(offs_of(c) + SW'(a >> 1)) & ~SW'(1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, expv);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_ch(input int c, input bit en, input logic [AW-1:0] a, input bit expect_it);
    exp_t e;
    cs[c] = en;
    addr[c*AW +: AW] = a;
    if (en && expect_it) begin
      e.ch = c; e.a = a; e.b = exp_byte(c, a); e.stamp = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (exp_q.size() > 0 && n < lim) begin tick(1); n++; end
    if (exp_q.size() > 0) begin
      chk("settle_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic wait_for(input int which, input bit val, input int lim);
    int n = 0;
    bit s;
    do begin
      @(negedge clk);
      s = (which == 0) ? sdram_req : data_rdy;
      n++;
    end while (s != val && n < lim);
    if (s != val) chk($sformatf("wait%0d_timeout", which), 32'(s), 32'(val));
  endtask

  task automatic do_reset();
    hold = 1'b0;
    tick(6);
    rst = 1'b1; cs = '0; addr = '0; downloading = 1'b0; loop_rst = 1'b0;
    exp_q.delete(); exp_req.delete();
    tick(3);
    rst = 1'b0;
  endtask

  // SDRAM controller stand-in: acks after ack_dly cycles, returns the pair after dat_dly (or with the ack).
  initial begin : sdram_model
    logic [SW-1:0] a;
    sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
    forever begin
      @(posedge clk); #1;
      if (sdram_req && !rst) begin
        a = sdram_addr;
        repeat (ack_dly) begin @(posedge clk); #1; end
        sdram_ack = 1'b1;
        if (same) begin data_rdy = 1'b1; data_read = {rom16(a + SW'(1)), rom16(a)}; end
        @(posedge clk); #1;
        sdram_ack = 1'b0; data_rdy = 1'b0;
        if (!same) begin
          while (hold) begin @(posedge clk); #1; end
          repeat (dat_dly) begin @(posedge clk); #1; end
          data_rdy = 1'b1; data_read = {rom16(a + SW'(1)), rom16(a)};
          @(posedge clk); #1;
          data_rdy = 1'b0;
        end
      end
    end
  end

  // Monitor: data checks when a channel presents ok, request-address checks on each new sdram_req.
  always @(negedge clk) begin : monitor
    int idx;
    bit legal;
    bit req_prev;
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        idx = -1;
        for (int j = 0; j < exp_q.size(); j++) if (idx < 0 && exp_q[j].ch == c) idx = j;
        if (idx >= 0 && ok[c] && exp_q[idx].stamp < cyc) begin
          chk($sformatf("dout%0d@%h", c, exp_q[idx].a), 32'(dout[c*8 +: 8]), 32'(exp_q[idx].b));
          exp_q.delete(idx);
        end
      end
      if (sdram_req && !req_prev) begin
        n_req++;
        if (exp_req.size() > 0) begin
          chk("req_addr", 32'(sdram_addr), 32'(exp_req.pop_front()));
        end else begin
          legal = 1'b0;
          for (int c = 0; c < CH; c++)
            if (cs[c] && sdram_addr == word_req(c, addr[c*AW +: AW])) legal = 1'b1;
          chk("req_addr_legal", 32'(legal), 32'd1);
        end
      end
    end
    req_prev = sdram_req;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin : main
    int nr;
    logic [AW-1:0] a;
    bit en;
    tick(3);
    @(negedge clk);
    chk("rst_ok", 32'(ok), 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_req", 32'(sdram_req), 32'd0);
    chk("rst_addr", 32'(sdram_addr), 32'd0);
    chk("rst_refresh", 32'(refresh_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single miss then a hit in the same word.
    ack_dly = 1; dat_dly = 2; same = 1'b0;
    exp_req.push_back(word_req(0, 15'h0005));
    set_ch(0, 1'b1, 15'h0005, 1'b1);
    wait_done(100);
    nr = n_req;
    set_ch(0, 1'b1, 15'h0007, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("hit_lat_ok", 32'(ok[0]), 32'd1);
    chk("hit_lat_dout", 32'(dout[7:0]), 32'(exp_byte(0, 15'h0007)));
    wait_done(20);
    chk("hit_no_req", n_req, nr);

    // Simultaneous misses: round-robin from rr+1, ch3 address wraps.
    do_reset();
    exp_req.push_back(word_req(1, 15'h0124));
    exp_req.push_back(word_req(2, 15'h2002));
    exp_req.push_back(word_req(3, 15'h7FFC));
    exp_req.push_back(word_req(0, 15'h0010));
    set_ch(0, 1'b1, 15'h0010, 1'b1);
    set_ch(1, 1'b1, 15'h0124, 1'b1);
    set_ch(2, 1'b1, 15'h2002, 1'b1);
    set_ch(3, 1'b1, 15'h7FFC, 1'b1);
    wait_done(400);
    chk("rr_all_served", exp_req.size(), 0);

    // Client moves during WAIT: fill lands on the stale tag, a second request follows.
    do_reset();
    hold = 1'b1; ack_dly = 0; dat_dly = 2;
    exp_req.push_back(word_req(1, 15'h0100));
    exp_req.push_back(word_req(1, 15'h0200));
    set_ch(1, 1'b1, 15'h0100, 1'b0);
    wait_for(0, 1'b1, 50);
    wait_for(0, 1'b0, 50);
    set_ch(1, 1'b1, 15'h0200, 1'b1);
    tick(2);
    hold = 1'b0;
    wait_for(1, 1'b1, 50);
    @(negedge clk);
    chk("stale_fill_ok1_a", 32'(ok[1]), 32'd0);
    @(negedge clk);
    chk("stale_fill_ok1_b", 32'(ok[1]), 32'd0);
    wait_done(200);
    chk("stale_refetch", exp_req.size(), 0);

    // Download during WAIT: everything dropped, then re-fetched.
    do_reset();
    ack_dly = 1; dat_dly = 1;
    set_ch(2, 1'b1, 15'h0333, 1'b1);
    wait_done(100);
    hold = 1'b1;
    exp_req.push_back(word_req(0, 15'h0400));
    set_ch(0, 1'b1, 15'h0400, 1'b1);
    wait_for(0, 1'b1, 50);
    wait_for(0, 1'b0, 50);
    nr = n_req;
    downloading = 1'b1;
    set_ch(2, 1'b1, 15'h0333, 1'b1);
    @(negedge clk);
    chk("dl_req", 32'(sdram_req), 32'd0);
    chk("dl_ok", 32'(ok), 32'd0);
    chk("dl_refresh", 32'(refresh_en), 32'd0);
    @(negedge clk);
    chk("dl_ok_hold", 32'(ok), 32'd0);
    downloading = 1'b0;
    hold = 1'b0;
    wait_done(300);
    chk("dl_refetch_cnt", n_req - nr, 2);

    // Idle refresh and a same-cycle ack+data fill.
    for (int c = 0; c < CH; c++) set_ch(c, 1'b0, '0, 1'b0);
    tick(3);
    @(negedge clk);
    chk("idle_refresh", 32'(refresh_en), 32'd1);
    same = 1'b1; ack_dly = 1;
    nr = n_req;
    exp_req.push_back(word_req(3, 15'h7FFD));
    set_ch(3, 1'b1, 15'h7FFD, 1'b1);
    wait_done(100);
    chk("same_cyc_single", n_req - nr, 1);
    tick(2);
    @(negedge clk);
    chk("same_cyc_idle", 32'(refresh_en), 32'd1);

    // Randomised traffic over a small set of words so hits and misses mix.
    for (int it = 0; it < 60; it++) begin
      @(posedge clk); #1;
      ack_dly = $urandom_range(0, 3);
      dat_dly = $urandom_range(0, 4);
      same = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin loop_rst = 1'b1; tick(1); loop_rst = 1'b0; end
      for (int c = 0; c < CH; c++) begin
        en = ($urandom_range(0, 3) != 0);
        a  = (AW'($urandom_range(0, 3)) << 10) | AW'($urandom_range(0, 7));
        set_ch(c, en, a, 1'b1);
      end
      wait_done(600);
      tick(3);
      @(negedge clk);
      chk("rand_idle", 32'(refresh_en), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
